// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared constants, encodings and CRC helpers for the USB packet receiver
// Purpose: PID byte values, rx_packet encoding, receiver state enum and the
//          byte-wide CRC5/CRC16 update functions used by rx_pkt_ctrl_usb.
// Ports:   none (package).
package usb_rx_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [4:0]  CRC5_INIT   = 5'h1F;
  localparam logic [4:0]  CRC5_POLY   = 5'h14;
  localparam logic [4:0]  CRC5_RESID  = 5'h06;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY  = 16'hA001;
  localparam logic [15:0] CRC16_RESID = 16'hB001;

  typedef enum logic [2:0] {
    PKT_NONE  = 3'd0,
    PKT_DATA  = 3'd1,
    PKT_ACK   = 3'd2,
    PKT_NAK   = 3'd3,
    PKT_STALL = 3'd4,
    PKT_IN    = 3'd5,
    PKT_OUT   = 3'd6
  } rx_pkt_e;

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_PID, S_TOK1, S_TOK2, S_DATA,
    S_HS_EOP, S_TOK_EOP, S_DONE, S_ERR, S_STOP
  } rx_state_e;

  // Bits enter LSB-first, matching the order they appear on the wire.
  function automatic logic [4:0] crc5_upd(input logic [4:0] crc, input logic [7:0] data);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC5_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/rx_data_hold_crc16.sv
// rtl/rx_data_hold_crc16.sv - two-deep data hold pipe with running CRC16
// Purpose: tracks how many data-stage bytes are held back (0..2) and folds
//          every data-stage byte into CRC16, so the last two bytes (the CRC)
//          are never released to the buffer.
// Ports:   clk, rst      - clock, synchronous active-high reset
//          clr_i         - restart for a new packet
//          push_i        - a data-stage byte is present this cycle
//          byte_i        - that byte
//          hold_full_o   - two bytes are held; the next push releases one
//          eop_ok_o      - an eop this cycle (after any push) would be valid
module rx_data_hold_crc16 import usb_rx_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       push_i,
  input  logic [7:0] byte_i,
  output logic       hold_full_o,
  output logic       eop_ok_o
);

  logic [1:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0] crc_q, crc_d;

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    crc_d      = crc_q;
    if (push_i) begin
      crc_d = crc16_upd(crc_q, byte_i);
      if (hold_cnt_q != 2'd2) hold_cnt_d = hold_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      hold_cnt_q <= 2'd0;
      crc_q      <= CRC16_INIT;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      crc_q      <= crc_d;
    end
  end

  assign hold_full_o = (hold_cnt_q == 2'd2);
  // Uses the post-push values so a byte and eop in the same cycle are judged
  // with that byte already included.
  assign eop_ok_o    = (crc_d == CRC16_RESID) && (hold_cnt_d == 2'd2);

endmodule

// File: rtl/rx_pkt_ctrl_usb.sv
// rtl/rx_pkt_ctrl_usb.sv - USB receive packet decoder and buffer-store controller
// Purpose: follows SYNC/PID/token/data/handshake bytes from the RX datapath,
//          validates PIDs, token CRC5/address/endpoint and data CRC16, drives
//          buffer store/flush strobes and reports the decoded packet.
// Ports:   clk, rst            - clock, synchronous active-high reset
//          eop, d_edge         - end-of-packet and line-activity pulses
//          byte_received       - rx_packet_data holds a new byte
//          buff_occupancy      - data buffer fill level
//          rx_packet           - decoded packet type, one cycle in DONE
//          flush, store_rx_pd  - buffer clear / store-byte strobes
//          rx_error            - one-cycle error pulse
//          rx_data_ready       - DATA packet completed cleanly
//          rx_transfer_active  - packet in progress
//          rx_byte_cnt         - payload bytes stored in this packet
module rx_pkt_ctrl_usb import usb_rx_pkg::*; #(
  parameter logic [6:0] DEV_ADDR = 7'd0,
  parameter logic [3:0] DEV_ENDP = 4'd0,
  parameter int         MAX_DATA = 64,
  parameter int         OCC_W    = 7,
  parameter int         TIMEOUT  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          eop,
  input  logic                          d_edge,
  input  logic                          byte_received,
  input  logic [7:0]                    rx_packet_data,
  input  logic [OCC_W-1:0]              buff_occupancy,
  output logic [2:0]                    rx_packet,
  output logic                          flush,
  output logic                          store_rx_pd,
  output logic                          rx_error,
  output logic                          rx_data_ready,
  output logic                          rx_transfer_active,
  output logic [$clog2(MAX_DATA+1)-1:0] rx_byte_cnt
);

  localparam int CNT_W = $clog2(MAX_DATA + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  rx_state_e        state_q, state_d;
  rx_pkt_e          pkt_q, pkt_d;
  logic [4:0]       crc5_q, crc5_d;
  logic [7:0]       tok_lo_q, tok_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  idle_q, idle_d;
  logic [2:0]       rx_packet_q, rx_packet_d;
  logic             flush_q, flush_d;
  logic             store_q, store_d;
  logic             err_q, err_d;
  logic             rdy_q, rdy_d;
  logic             active_q, active_d;

  logic       pkt_start;
  logic       data_push;
  logic       hold_full;
  logic       eop_ok;
  logic       buf_full;
  logic [4:0] crc5_nxt;

  assign pkt_start = (state_q == S_IDLE) && d_edge;
  assign data_push = (state_q == S_DATA) && byte_received;
  assign buf_full  = (buff_occupancy == {OCC_W{1'b1}});
  assign crc5_nxt  = crc5_upd(crc5_q, rx_packet_data);

  rx_data_hold_crc16 u_hold (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (pkt_start),
    .push_i      (data_push),
    .byte_i      (rx_packet_data),
    .hold_full_o (hold_full),
    .eop_ok_o    (eop_ok)
  );

  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    crc5_d      = crc5_q;
    tok_lo_d    = tok_lo_q;
    cnt_d       = cnt_q;
    idle_d      = '0;
    rx_packet_d = PKT_NONE;
    flush_d     = 1'b0;
    store_d     = 1'b0;
    err_d       = 1'b0;
    rdy_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (d_edge) begin
          state_d = S_SYNC;
          cnt_d   = '0;
          crc5_d  = CRC5_INIT;
        end
      end
      S_SYNC: begin
        if (eop) state_d = S_ERR;
        else if (byte_received) begin
          if (rx_packet_data == SYNC_BYTE) begin
            state_d = S_PID;
            flush_d = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_PID: begin
        if (eop) state_d = S_ERR;
        else if (byte_received) begin
          if (rx_packet_data[7:4] != ~rx_packet_data[3:0]) state_d = S_ERR;
          else begin
            case (rx_packet_data)
              PID_IN:    begin state_d = S_TOK1;   pkt_d = PKT_IN;    end
              PID_OUT:   begin state_d = S_TOK1;   pkt_d = PKT_OUT;   end
              PID_DATA0: begin state_d = S_DATA;   pkt_d = PKT_DATA;  end
              PID_DATA1: begin state_d = S_DATA;   pkt_d = PKT_DATA;  end
              PID_ACK:   begin state_d = S_HS_EOP; pkt_d = PKT_ACK;   end
              PID_NAK:   begin state_d = S_HS_EOP; pkt_d = PKT_NAK;   end
              PID_STALL: begin state_d = S_HS_EOP; pkt_d = PKT_STALL; end
              default:   state_d = S_ERR;
            endcase
          end
        end
      end
      S_TOK1: begin
        if (eop) state_d = S_ERR;
        else if (byte_received) begin
          tok_lo_d = rx_packet_data;
          crc5_d   = crc5_nxt;
          state_d  = S_TOK2;
        end
      end
      S_TOK2: begin
        if (eop) state_d = S_ERR;
        else if (byte_received) begin
          // addr = byte0[6:0], endp = {byte1[2:0], byte0[7]}
          if ((crc5_nxt == CRC5_RESID) && (tok_lo_q[6:0] == DEV_ADDR) &&
              ({rx_packet_data[2:0], tok_lo_q[7]} == DEV_ENDP))
            state_d = S_TOK_EOP;
          else
            state_d = S_ERR;
        end
      end
      S_DATA: begin
        // The byte is taken first; a same-cycle eop then sees it included.
        if (byte_received && hold_full) begin
          if ((cnt_q == MAX_CNT) || buf_full) state_d = S_ERR;
          else begin
            store_d = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        if (eop && (state_d != S_ERR)) state_d = eop_ok ? S_DONE : S_ERR;
      end
      S_HS_EOP, S_TOK_EOP: begin
        if (eop) state_d = S_DONE;
        else if (byte_received) state_d = S_ERR;
      end
      S_DONE:  state_d = S_STOP;
      S_ERR:   state_d = S_STOP;
      S_STOP: begin
        if (!eop && !d_edge) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte watchdog for every state that is waiting on the line.
    if (state_q inside {S_SYNC, S_PID, S_TOK1, S_TOK2, S_DATA, S_HS_EOP, S_TOK_EOP}) begin
      if (!byte_received && !eop) begin
        idle_d = idle_q + 1'b1;
        if (idle_q == TO_LAST) state_d = S_ERR;
      end
    end

    // DONE and ERR always exit after one cycle, so these fire on entry only.
    if (state_d == S_DONE) begin
      rx_packet_d = pkt_q;
      rdy_d       = (pkt_q == PKT_DATA);
    end
    if (state_d == S_ERR) begin
      err_d   = 1'b1;
      flush_d = 1'b1;
    end
  end

  assign active_d = state_d inside {S_SYNC, S_PID, S_TOK1, S_TOK2, S_DATA,
                                    S_HS_EOP, S_TOK_EOP, S_DONE};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pkt_q       <= PKT_NONE;
      crc5_q      <= CRC5_INIT;
      tok_lo_q    <= '0;
      cnt_q       <= '0;
      idle_q      <= '0;
      rx_packet_q <= '0;
      flush_q     <= 1'b0;
      store_q     <= 1'b0;
      err_q       <= 1'b0;
      rdy_q       <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_q       <= pkt_d;
      crc5_q      <= crc5_d;
      tok_lo_q    <= tok_lo_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      rx_packet_q <= rx_packet_d;
      flush_q     <= flush_d;
      store_q     <= store_d;
      err_q       <= err_d;
      rdy_q       <= rdy_d;
      active_q    <= active_d;
    end
  end

  assign rx_packet          = rx_packet_q;
  assign flush              = flush_q;
  assign store_rx_pd        = store_q;
  assign rx_error           = err_q;
  assign rx_data_ready      = rdy_q;
  assign rx_transfer_active = active_q;
  assign rx_byte_cnt        = cnt_q;

endmodule
